// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared state encoding, default sizes and round-robin search for conv_mac_sched.
package conv_sched_pkg;

   typedef enum logic [2:0] {IDLE, MAC, DRAIN, CAP, OUT, REL} state_t;

   localparam int WIDTH_DEF = 11;
   localparam int LENX_DEF  = 30;
   localparam int LENF_DEF  = 9;
   localparam int MAX_CH    = 32;

   // First set request at or above ptr, wrapping at n; lowest offset wins.
   function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int n, input int ptr);
      int idx;
      rr_pick = 0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (i < n) begin
            idx = (ptr + i) % n;
            if (req[idx[$clog2(MAX_CH)-1:0]]) rr_pick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over NUM_CH requests; pointer moves past the released channel.
module rr_arbiter
   import conv_sched_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CHW    = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] req,
   input  logic              rel,
   input  logic [CHW-1:0]    rel_idx,
   output logic [CHW-1:0]    grant,
   output logic              any
);

   logic [CHW-1:0] ptr;

   assign any   = |req;
   assign grant = CHW'(rr_pick(MAX_CH'(req), NUM_CH, int'(ptr)));

   always_ff @(posedge clk or negedge reset)
      if (!reset)
         ptr <= '0;
      else if (rel)
         ptr <= (int'(rel_idx) == NUM_CH - 1) ? '0 : rel_idx + 1'b1;

endmodule

// File: rtl/conv_mac_sched.sv
// conv_mac_sched: round-robin scheduler sharing one MAC convolution datapath across channels.
// Define CONV_RELU_EN to clamp negative captured results to zero.
module conv_mac_sched
   import conv_sched_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int LENX   = LENX_DEF,
   parameter int LENF   = LENF_DEF,
   parameter int NUM_CH = 2,
   parameter int ADDRX  = $clog2(LENX),
   parameter int ADDRF  = $clog2(LENF),
   parameter int CHW    = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       buf_full,
   output logic [NUM_CH-1:0]       buf_release,
   output logic [CHW-1:0]          rd_sel,
   output logic [ADDRX-1:0]        addr_x,
   output logic [ADDRF-1:0]        addr_f,
   output logic                    clr_acc,
   output logic                    en_acc,
   input  logic signed [WIDTH-1:0] acc_in,
   output logic signed [WIDTH-1:0] m_data_out_y,
   output logic [CHW-1:0]          m_ch_y,
   output logic                    m_valid_y,
   input  logic                    m_ready_y,
   output logic                    busy
);

   localparam int NOUT = LENX - LENF + 1;
   localparam logic [ADDRX-1:0] W_LAST = ADDRX'(NOUT - 1);
   localparam logic [ADDRF-1:0] K_LAST = ADDRF'(LENF - 1);

   state_t state, nxt;
   logic [ADDRX-1:0] w, ax_q;
   logic [ADDRF-1:0] k, af_q;
   logic [CHW-1:0] grant;
   logic any, hs;
   logic signed [WIDTH-1:0] cap_val;

   rr_arbiter #(.NUM_CH(NUM_CH), .CHW(CHW)) u_arb (
      .clk(clk),
      .reset(reset),
      .req(buf_full),
      .rel(state == REL),
      .rel_idx(rd_sel),
      .grant(grant),
      .any(any)
   );

`ifdef CONV_RELU_EN
   assign cap_val = acc_in[WIDTH-1] ? '0 : acc_in;
`else
   assign cap_val = acc_in;
`endif

   // Addresses are live only while issuing; afterwards the last issued pair is held.
   assign addr_x      = (state == MAC) ? w + ADDRX'(k) : ax_q;
   assign addr_f      = (state == MAC) ? k : af_q;
   assign clr_acc     = (state == MAC) && (k == '0);
   assign busy        = state != IDLE;
   assign hs          = m_valid_y && m_ready_y;
   assign buf_release = (state == REL) ? NUM_CH'(1) << rd_sel : '0;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = any ? MAC : IDLE;
         MAC:     nxt = (k == K_LAST) ? DRAIN : MAC;
         DRAIN:   nxt = CAP;
         CAP:     nxt = OUT;
         OUT:     nxt = !hs ? OUT : (w == W_LAST) ? REL : MAC;
         REL:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state        <= IDLE;
         w            <= '0;
         k            <= '0;
         ax_q         <= '0;
         af_q         <= '0;
         rd_sel       <= '0;
         en_acc       <= 1'b0;
         m_data_out_y <= '0;
         m_ch_y       <= '0;
         m_valid_y    <= 1'b0;
      end else begin
         state  <= nxt;
         en_acc <= state == MAC;
         k      <= (state == MAC) ? k + 1'b1 : '0;
         if (state == IDLE && any) rd_sel <= grant;
         if (state == IDLE) w <= '0;
         else if (state == OUT && hs && w != W_LAST) w <= w + 1'b1;
         if (state == MAC) begin
            ax_q <= addr_x;
            af_q <= addr_f;
         end
         if (state == CAP) begin
            m_data_out_y <= cap_val;
            m_ch_y       <= rd_sel;
            m_valid_y    <= 1'b1;
         end else if (state == OUT && hs) begin
            m_valid_y <= 1'b0;
         end
      end

endmodule

// File: tb/tb_conv_mac_sched.sv
// tb_conv_mac_sched: scoreboard bench for conv_mac_sched with a mock x-buffer/ROM/accumulator datapath.
module tb_conv_mac_sched;

   localparam int W = 11, LX = 30, LF = 9, NC = 2, NOUT = LX - LF + 1;

   logic clk = 1'b0, reset = 1'b0;
   logic [NC-1:0] buf_full = '0, buf_release;
   logic [0:0] rd_sel, m_ch_y;
   logic [4:0] addr_x;
   logic [3:0] addr_f;
   logic clr_acc, en_acc, m_valid_y, busy, m_ready_y;
   logic signed [W-1:0] acc_in, m_data_out_y;
   logic ready_man = 1'b1, rnd_on = 1'b0, rnd_bit = 1'b1, mock = 1'b0;
   logic signed [W-1:0] mock_val = '0;
   logic signed [W-1:0] xmem [NC][LX];
   logic signed [W-1:0] fmem [LF];
   logic signed [W-1:0] xd, fd, acc;
   int total = 0, bad = 0, rel_cnt = 0, hs_cnt = 0;
   int exp_d[$], exp_c[$], rel_q[$];

   always #5 clk = ~clk;

   assign m_ready_y = rnd_on ? rnd_bit : ready_man;
   assign acc_in    = mock ? mock_val : acc;

   // Stand-in datapath: synchronous-read x buffers and filter ROM feeding a wrapping accumulator.
   always @(posedge clk) begin
      xd <= xmem[rd_sel][addr_x];
      fd <= fmem[addr_f];
      if (clr_acc) acc <= '0;
      else if (en_acc) acc <= acc + xd * fd;
   end

   conv_mac_sched dut (
      .clk(clk),
      .reset(reset),
      .buf_full(buf_full),
      .buf_release(buf_release),
      .rd_sel(rd_sel),
      .addr_x(addr_x),
      .addr_f(addr_f),
      .clr_acc(clr_acc),
      .en_acc(en_acc),
      .acc_in(acc_in),
      .m_data_out_y(m_data_out_y),
      .m_ch_y(m_ch_y),
      .m_valid_y(m_valid_y),
      .m_ready_y(m_ready_y),
      .busy(busy)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int relu(input int v);
`ifdef CONV_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   function automatic int ref_y(input int ch, input int w);
      int s;
      logic signed [W-1:0] t;
      s = 0;
      for (int k = 0; k < LF; k++) s += int'(xmem[ch][w+k]) * int'(fmem[k]);
      t = W'(s);
      return relu(int'(t));
   endfunction

   task automatic push_outs(input int ch);
      for (int w = 0; w < NOUT; w++) begin
         exp_d.push_back(mock ? relu(int'(mock_val)) : ref_y(ch, w));
         exp_c.push_back(ch);
      end
   endtask

   task automatic push_srv(input int ch);
      push_outs(ch);
      rel_q.push_back(ch);
   endtask

   task automatic fill_x();
      for (int c = 0; c < NC; c++)
         for (int i = 0; i < LX; i++) xmem[c][i] = W'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic wait_rel(input int n);
      for (int i = 0; i < 6000 && rel_cnt < n; i++) begin
         @(posedge clk);
         #1;
      end
      chk("release_count", rel_cnt, n);
      chk("outs_before_release", exp_d.size(), 0);
   endtask

   task automatic wait_hs(input int n);
      for (int i = 0; i < 2000 && hs_cnt < n; i++) begin
         @(posedge clk);
         #1;
      end
      chk("handshake_count", hs_cnt, n);
   endtask

   initial forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   // Monitor: pops the scoreboard on every handshake and release pulse.
   initial begin
      logic pv;
      int pd, pc;
      pv = 1'b0;
      pd = 0;
      pc = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            pv = 1'b0;
         end else begin
            chk("addr_x_range", int'(addr_x <= 5'(LX - 1)), 1);
            chk("en_acc_idle_out", int'(en_acc && (m_valid_y || !busy)), 0);
            if (pv) begin
               chk("hold_valid", int'(m_valid_y), 1);
               chk("hold_data", int'(m_data_out_y), pd);
               chk("hold_ch", int'(m_ch_y), pc);
            end
            if (m_valid_y && m_ready_y) begin
               hs_cnt++;
               if (exp_d.size() == 0) chk("unexpected_output", 1, 0);
               else begin
                  chk("out_data", int'(m_data_out_y), exp_d.pop_front());
                  chk("out_ch", int'(m_ch_y), exp_c.pop_front());
               end
            end
            if (buf_release != '0) begin
               rel_cnt++;
               if (rel_q.size() == 0) chk("unexpected_release", int'(buf_release), 0);
               else chk("release_ch", int'(buf_release), 1 << rel_q.pop_front());
            end
            pv = m_valid_y && !m_ready_y;
            pd = int'(m_data_out_y);
            pc = int'(m_ch_y);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int base, n;
      logic signed [W-1:0] d;
      for (int i = 0; i < LF; i++) fmem[i] = W'($urandom);
      fill_x();
      do_reset();
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(m_valid_y), 0);
      chk("rst_release", int'(buf_release), 0);
      chk("rst_en_acc", int'(en_acc), 0);
      chk("rst_addr_x", int'(addr_x), 0);

      // Single channel, window 3 held off by backpressure for 5 cycles.
      push_srv(0);
      base = hs_cnt;
      buf_full = 2'b01;
      wait_hs(base + 3);
      ready_man = 1'b0;
      for (n = 0; n < 40 && !m_valid_y; n++) begin
         @(posedge clk);
         #1;
      end
      chk("bp_valid", int'(m_valid_y), 1);
      d = m_data_out_y;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", int'(m_valid_y), 1);
         chk("bp_hold_data", int'(m_data_out_y), int'(d));
         chk("bp_no_acc", int'(en_acc || clr_acc), 0);
         chk("bp_addr_x", int'(addr_x), 3 + LF - 1);
         @(posedge clk);
         #1;
      end
      ready_man = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid_drop", int'(m_valid_y), 0);
      chk("bp_w4_clr", int'(clr_acc), 1);
      chk("bp_w4_addr_x", int'(addr_x), 4);
      chk("bp_w4_addr_f", int'(addr_f), 0);
      wait_rel(rel_cnt + 1);
      buf_full = '0;

      // Both channels together: ch0, ch1, then back to ch0, under random ready.
      do_reset();
      fill_x();
      rnd_on = 1'b1;
      push_srv(0);
      push_srv(1);
      push_srv(0);
      buf_full = 2'b11;
      wait_rel(rel_cnt + 3);
      buf_full = '0;
      rnd_on = 1'b0;
      @(posedge clk);
      #1;
      chk("both_idle", int'(busy), 0);

      // Issue/enable timing against a constant accumulator.
      do_reset();
      mock = 1'b1;
      mock_val = 11'sh07F;
      push_srv(0);
      buf_full = 2'b01;
      for (n = 0; n < 20 && !clr_acc; n++) begin
         @(posedge clk);
         #1;
      end
      for (int c = 0; c < 12; c++) begin
         if (c < LF) begin
            chk("t_addr_f", int'(addr_f), c);
            chk("t_addr_x", int'(addr_x), c);
         end
         if (c == LF) chk("t_drain_hold", int'(addr_x), LF - 1);
         chk("t_clr", int'(clr_acc), int'(c == 0));
         chk("t_en", int'(en_acc), int'(c >= 1 && c <= LF));
         chk("t_valid", int'(m_valid_y), int'(c == LF + 2));
         @(posedge clk);
         #1;
      end
      wait_rel(rel_cnt + 1);
      buf_full = '0;

      // Negative result through the capture stage.
      do_reset();
      mock_val = -11'sd5;
      push_srv(0);
      buf_full = 2'b01;
      wait_rel(rel_cnt + 1);
      buf_full = '0;
      mock = 1'b0;

      // Reset in the middle of ch1 service; restart from window 0, one release only.
      do_reset();
      fill_x();
      push_srv(1);
      buf_full = 2'b10;
      base = rel_cnt;
      wait_hs(hs_cnt + 2);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rd_sel", int'(rd_sel), 1);
      chk("mid_busy", int'(busy), 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", int'(m_valid_y), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_en", int'(en_acc), 0);
      chk("arst_clr", int'(clr_acc), 0);
      chk("arst_addr_x", int'(addr_x), 0);
      chk("arst_addr_f", int'(addr_f), 0);
      chk("arst_rd_sel", int'(rd_sel), 0);
      chk("arst_data", int'(m_data_out_y), 0);
      chk("arst_release", int'(buf_release), 0);
      exp_d.delete();
      exp_c.delete();
      push_outs(1);
      @(posedge clk);
      #1 reset = 1'b1;
      wait_rel(base + 1);
      buf_full = '0;
      chk("rel_q_empty", rel_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
